// File: rtl/count_bcd_display.sv
// Samples a 0..127 count, converts it to three BCD digits with a bit-serial double-dabble
// engine, and drives a multiplexed three-digit 7-segment display with leading-zero blanking.
module count_bcd_display #(
  parameter int unsigned COUNT_MAX   = 100,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] count_in,
  input  logic       load,
  output logic       busy,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bcd_valid,
  output logic       range_err,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      shift_q, shift_d;
  logic [6:0]      cap_q, cap_d;
  logic [9:0]      scratch_q, scratch_d;
  logic [9:0]      adj;
  logic [2:0]      iter_q, iter_d;
  logic [3:0]      hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic            rerr_q, rerr_d, valid_q, valid_d;
  logic [CntW-1:0] rcnt_q, rcnt_d;
  logic [1:0]      didx_q, didx_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      an_q, an_d;
  logic [3:0]      sel;
  logic            blank;
  logic            wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cap_d     = cap_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    rerr_d    = rerr_q;
    valid_d   = 1'b0;
    adj       = scratch_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          cap_d     = count_in;
          shift_d   = count_in;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        // Hundreds is at most 1, so only tens and ones ever need the +3 correction.
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        {scratch_d, shift_d} = {adj[8:0], shift_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd6) state_d = StDone;
      end
      StDone: begin
        hund_d  = {2'b00, scratch_q[9:8]};
        tens_d  = scratch_q[7:4];
        ones_d  = scratch_q[3:0];
        rerr_d  = 32'(cap_q) > COUNT_MAX;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Display path runs freely; it always shows the latched digits from the previous cycle.
  always_comb begin
    wrap   = (rcnt_q == CntW'(REFRESH_DIV - 1));
    rcnt_d = wrap ? '0 : rcnt_q + CntW'(1);
    didx_d = didx_q;
    if (wrap) didx_d = (didx_q == 2'd2) ? 2'd0 : didx_q + 2'd1;
    case (didx_d)
      2'd0: begin
        an_d  = 3'b001;
        sel   = ones_q;
        blank = 1'b0;
      end
      2'd1: begin
        an_d  = 3'b010;
        sel   = tens_q;
        blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      default: begin
        an_d  = 3'b100;
        sel   = hund_q;
        blank = (hund_q == 4'd0);
      end
    endcase
    seg_d = blank ? 7'h00 : seg_decode(sel);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cap_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      rerr_q    <= 1'b0;
      valid_q   <= 1'b0;
      rcnt_q    <= '0;
      didx_q    <= 2'd0;
      seg_q     <= 7'h3F;
      an_q      <= 3'b001;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cap_q     <= cap_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      rerr_q    <= rerr_d;
      valid_q   <= valid_d;
      rcnt_q    <= rcnt_d;
      didx_q    <= didx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign bcd_hundreds = hund_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;
  assign bcd_valid    = valid_q;
  assign range_err    = rerr_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: per-cycle arithmetic reference model plus directed
// literal checks and a randomized load/reset phase.
module tb_count_bcd_display;

  localparam int DIV  = 4;
  localparam int CMAX = 100;

  logic       clk, rst, load, busy, bcd_valid, range_err;
  logic [6:0] count_in, seg;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
  logic [2:0] an;

  int total = 0;
  int bad   = 0;

  count_bcd_display #(.COUNT_MAX(CMAX), .REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .load        (load),
    .busy        (busy),
    .bcd_hundreds(bcd_hundreds),
    .bcd_tens    (bcd_tens),
    .bcd_ones    (bcd_ones),
    .bcd_valid   (bcd_valid),
    .range_err   (range_err),
    .seg         (seg),
    .an          (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Segment pattern for display slot d (0 ones, 1 tens, 2 hundreds) of digits h/t/o.
  function automatic logic [6:0] disp(input int d, input int h, input int t, input int o);
    int v;
    bit blk;
    if (d == 0) begin v = o; blk = 0; end
    else if (d == 1) begin v = t; blk = (h == 0) && (t == 0); end
    else begin v = h; blk = (h == 0); end
    if (blk || v > 9) return 7'h00;
    return lut[v];
  endfunction

  // Reference model: a conversion is a countdown of 8 edges, then plain decimal arithmetic.
  bit         m_on = 0;
  int         n, pend, mval, mh, mt, mo, dig;
  bit         mr, mv;
  logic [6:0] mseg;
  logic [2:0] man;

  initial begin
    bit r, l;
    logic [6:0] c;
    forever begin
      @(posedge clk);
      r = rst; l = load; c = count_in;
      if (!r) begin
        m_on = 1; n = 0; pend = 0; mh = 0; mt = 0; mo = 0; mr = 0; mv = 0;
        mseg = 7'h3F; man = 3'b001;
      end else if (m_on) begin
        n++;
        dig  = (n / DIV) % 3;
        man  = 3'b001 << dig;
        mseg = disp(dig, mh, mt, mo);
        mv   = 0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mh = mval / 100; mt = (mval / 10) % 10; mo = mval % 10;
            mr = (mval > CMAX); mv = 1;
          end
        end else if (l) begin
          pend = 8; mval = int'(c);
        end
      end
      #1;
      if (m_on) begin
        chk("m_busy", busy, pend > 0);
        chk("m_valid", bcd_valid, mv);
        chk("m_hund", bcd_hundreds, mh);
        chk("m_tens", bcd_tens, mt);
        chk("m_ones", bcd_ones, mo);
        chk("m_rerr", range_err, mr);
        chk("m_seg", seg, mseg);
        chk("m_an", an, man);
      end
    end
  end

  task automatic do_load(input logic [6:0] v);
    load = 1'b1; count_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (bcd_valid !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic conv(input logic [6:0] v, input int eh, input int et, input int eo, input bit er);
    int k;
    do_load(v);
    wait_valid(k);
    chk("latency", k, 8);
    chk("hund", bcd_hundreds, eh);
    chk("tens", bcd_tens, et);
    chk("ones", bcd_ones, eo);
    chk("range_err", range_err, er);
    chk("busy_at_valid", busy, 0);
  endtask

  task automatic wait_an(input logic [2:0] target);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (an !== target && k < 20);
    chk("an_reach", an, target);
  endtask

  task automatic check_frame(input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh);
    wait_an(3'b100);
    wait_an(3'b001); chk("seg_ones", seg, so);
    wait_an(3'b010); chk("seg_tens", seg, st);
    wait_an(3'b100); chk("seg_hund", seg, sh);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; load = 1'b0; count_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 3'b001);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_busy", busy, 0);
    chk("rst_digits", {bcd_hundreds, bcd_tens, bcd_ones}, 0);
    chk("rst_rerr", range_err, 0);
    rst = 1'b1;

    conv(7'd100, 1, 0, 0, 0);
    check_frame(7'h3F, 7'h3F, 7'h06);
    conv(7'd7, 0, 0, 7, 0);
    check_frame(7'h07, 7'h00, 7'h00);
    conv(7'd42, 0, 4, 2, 0);
    check_frame(7'h5B, 7'h66, 7'h00);
    conv(7'd127, 1, 2, 7, 1);
    conv(7'd0, 0, 0, 0, 0);

    // Load during conversion must be dropped.
    do_load(7'd99);
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; count_in = 7'd55;
    @(negedge clk);
    load = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulses++;
    end
    chk("busy_load_pulses", pulses, 1);
    chk("busy_load_digits", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h099);

    // Load in the bcd_valid cycle is accepted.
    begin
      int k;
      do_load(7'd99);
      wait_valid(k);
      chk("b2b_first", k, 8);
      conv(7'd12, 0, 1, 2, 0);
    end

    // Reset on the 4th conversion edge.
    do_load(7'd99);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_digits", {bcd_hundreds, bcd_tens, bcd_ones}, 0);
    rst = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulses++;
    end
    chk("midrst_novalid", pulses, 0);
    conv(7'd63, 0, 6, 3, 0);

    repeat (1500) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) != 0);
      load     = ($urandom_range(0, 2) == 0);
      count_in = 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Downstream display stage for the 0–100 free-running counter. It samples the 7-bit count on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It holds the result and drives a time-multiplexed, three-digit, common-anode-style 7-segment display with leading-zero blanking.

## Interface
- COUNT_MAX, 100: largest legal input; larger values still convert but flag `range_err`.
- REFRESH_DIV, 1000: clk cycles each digit stays enabled; legal range ≥ 2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- count_in  in  7  counter value, sampled only when a load is accepted.
- load  in  1  sample request; honoured only in IDLE.
- busy  out  1  high in CONVERT and DONE.
- bcd_hundreds, bcd_tens, bcd_ones  out  4 each  latched BCD result.
- bcd_valid  out  1  one-cycle pulse when a new result is latched.
- range_err  out  1  latched with the result; 1 if the sampled value is > COUNT_MAX.
- seg  out  7  segment drive, active-high: seg[0]=a … seg[6]=g.
- an  out  3  one-hot digit enable, active-high: an[0]=ones, an[1]=tens, an[2]=hundreds.

## Operation
- **FSM states:** IDLE, CONVERT, DONE.
- **IDLE:** if load=1, capture count_in into the shift register, clear the BCD scratch, set iter=0, and go to CONVERT.
- **CONVERT:** each cycle, in this order:
  - add 3 to every scratch digit ≥ 5;
  - shift {scratch, shift reg} left by 1;
  - increment iter.
  - After the 7th iteration, go to DONE.
- **DONE:**
  - copy the scratch into the bcd_* outputs;
  - set range_err = (captured value > COUNT_MAX);
  - pulse bcd_valid;
  - return to IDLE.
- **load while busy** (CONVERT or DONE) is ignored, not queued.
- **Arithmetic:** inputs 0–127 are all valid. Hundreds is 0 or 1; the scratch is 10 bits wide (hundreds needs only 2 bits, zero-extended on output).
- **Display refresh:**
  - The refresh counter runs 0..REFRESH_DIV-1 continuously and is independent of the FSM.
  - On wrap, the digit index advances ones→tens→hundreds→ones.
  - seg and an are registered and change on the same edge.
  - The display always shows the latched bcd_* registers, so it changes only on the cycle after bcd_valid.
- **Segment codes (hex):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; any value >9 decodes to 00.
- **Leading-zero blanking:**
  - Hundreds digit is blanked (seg=00) when it is 0.
  - Tens digit is blanked when hundreds=0 and tens=0.
  - Ones digit is never blanked.
  - an still cycles through blanked digits.
- **Reset (rst=0 at an edge), including mid-conversion:**
  - Any conversion is aborted and the FSM goes to IDLE.
  - busy=0, bcd_valid=0, range_err=0, all bcd_*=0.
  - Refresh counter=0, digit index=ones, an=001, seg=3F.

## Timing
- **Latency:** a load is accepted at edge E0 (state IDLE).
  - busy=1 from after E0.
  - Iterations happen on edges E1–E7; DONE is occupied after E7.
  - Edge E8 updates bcd_*/range_err and raises bcd_valid for exactly one cycle; busy=0 in that same cycle.
- **Throughput:** the next load can be accepted in the cycle bcd_valid is high, giving one conversion per 9 cycles.
- **Digit dwell:** each digit is enabled for exactly REFRESH_DIV cycles; a full display frame is 3×REFRESH_DIV cycles.
- **Output stability:** bcd_* and range_err are stable between bcd_valid pulses.
- **Simultaneous events:** load coinciding with rst=0 is discarded (reset wins).

## Test plan
- **Reset:** hold rst=0 for 3 cycles, release → an=001, seg=3F, busy=0, bcd_*=0, range_err=0.
- **Max legal value:** load count_in=100 → busy for 8 cycles; bcd_valid high 8 edges after the load edge; digits 1/0/0; range_err=0. With REFRESH_DIV=4, seg sequence 3F,3F,06 for an 001,010,100.
- **Leading-zero blanking:** load 7 → digits 0/0/7; seg=07 on ones, 00 on tens and hundreds. Load 42 → tens=66, ones=5B, hundreds blank.
- **Out-of-range input:** load 127 with COUNT_MAX=100 → digits 1/2/7, range_err=1. A following load of 0 → digits 0/0/0, range_err=0.
- **Load while busy:** pulse load=1 with count_in=55 on the 3rd CONVERT cycle of a conversion of 99 → result 9/9, only one bcd_valid pulse; a load in the bcd_valid cycle is accepted.
- **Reset mid-conversion:** rst=0 on the 4th CONVERT edge → busy=0 and bcd_*=0 next cycle, no bcd_valid; a fresh load of 63 then completes normally in 8 cycles.
